// File: rtl/kamus_fetch_ctrl.sv
// Fetch sequencer for the kamus IF stage: owns the PC, runs the single-outstanding
// imem req/gnt/rvalid handshake and feeds decode through a one-entry valid/ready register.
module kamus_fetch_ctrl #(
  parameter logic [31:0] BOOT_ADDR = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        fetch_en_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_addr_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] instr_addr_o,
  input  logic        instr_ready_i
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  state_e      state_r;
  state_e      state_next_s;
  logic [31:0] pc_r;
  logic [31:0] req_addr_r;
  logic        discard_r;
  logic        instr_valid_r;
  logic [31:0] instr_r;
  logic [31:0] instr_addr_r;

  logic        issue_s;
  logic        grant_s;
  logic        resp_s;
  logic        deliver_s;
  logic [31:0] redirect_pc_s;

  // A request is only issued when its response is guaranteed a free output slot.
  assign issue_s       = fetch_en_i & (~instr_valid_r | instr_ready_i);
  assign grant_s       = (state_r == ST_REQ) & issue_s & imem_gnt_i;
  assign resp_s        = (state_r == ST_WAIT) & imem_rvalid_i;
  assign deliver_s     = resp_s & ~discard_r & ~redirect_i;
  assign redirect_pc_s = redirect_addr_i & 32'hFFFF_FFFC;

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; redirect only changes the WAIT exit (response dropped).
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (fetch_en_i) state_next_s = ST_REQ;
        else            state_next_s = ST_IDLE;
      end
      ST_REQ: begin
        if (grant_s)          state_next_s = ST_WAIT;
        else if (!fetch_en_i) state_next_s = ST_IDLE;
        else                  state_next_s = ST_REQ;
      end
      ST_WAIT: begin
        if (imem_rvalid_i) begin
          if (discard_r || redirect_i || fetch_en_i) state_next_s = ST_REQ;
          else                                       state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_WAIT;
        end
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Output decode for the memory request.
  always_comb begin
    imem_req_o = 1'b0;
    case (state_r)
      ST_REQ:  imem_req_o = issue_s;
      ST_IDLE: imem_req_o = 1'b0;
      ST_WAIT: imem_req_o = 1'b0;
      default: imem_req_o = 1'b0;
    endcase
  end

  // PC, granted-address latch and stale-response flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_r       <= BOOT_ADDR & 32'hFFFF_FFFC;
      req_addr_r <= 32'h0000_0000;
      discard_r  <= 1'b0;
    end else begin
      if (redirect_i)     pc_r <= redirect_pc_s;
      else if (deliver_s) pc_r <= pc_r + 32'd4;
      else                pc_r <= pc_r;

      if (grant_s) req_addr_r <= pc_r;
      else         req_addr_r <= req_addr_r;

      // A redirect while a response is still owed marks that response stale.
      if (redirect_i && (((state_r == ST_WAIT) && !imem_rvalid_i) || grant_s))
        discard_r <= 1'b1;
      else if (resp_s)
        discard_r <= 1'b0;
      else
        discard_r <= discard_r;
    end
  end

  // Single-entry output register toward decode.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      instr_valid_r <= 1'b0;
      instr_r       <= 32'h0000_0000;
      instr_addr_r  <= 32'h0000_0000;
    end else begin
      if (redirect_i) begin
        instr_valid_r <= 1'b0;
      end else if (deliver_s) begin
        instr_valid_r <= 1'b1;
        instr_r       <= imem_rdata_i;
        instr_addr_r  <= req_addr_r;
      end else if (instr_valid_r && instr_ready_i) begin
        instr_valid_r <= 1'b0;
      end else begin
        instr_valid_r <= instr_valid_r;
      end
    end
  end

  assign imem_addr_o   = pc_r;
  assign instr_valid_o = instr_valid_r;
  assign instr_o       = instr_r;
  assign instr_addr_o  = instr_addr_r;

endmodule
